// File: rtl/iob_eth_tx_mii.sv
// MII transmit framer: drains the TX frame buffer as preamble/SFD, payload nibbles and an IFG.
// Optional hardware FCS (CRC-32) is enabled by defining ETH_TX_FCS_EN.
module iob_eth_tx_mii #(
  parameter int ADDR_W      = 11,
  parameter int IFG_NIBBLES = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [ADDR_W-1:0] nbytes,
  output logic              ready,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic              TX_EN,
  output logic [3:0]        TX_DATA
);

  localparam int CNT_W = ($clog2(IFG_NIBBLES) > 4) ? $clog2(IFG_NIBBLES) : 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
`ifdef ETH_TX_FCS_EN
    FCS  = 3'd3,
`endif
    IFG  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [ADDR_W-1:0]   bcnt_r, bcnt_s;
  logic [ADDR_W-1:0]   nbytes_r, nbytes_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                half_r, half_s;
  logic [3:0]          hold_r, hold_s;
  logic                tx_en_r, tx_en_s;
  logic [3:0]          tx_data_r, tx_data_s;
  logic                ready_r, ready_s;

`ifdef ETH_TX_FCS_EN
  logic [31:0]         crc_r, crc_s;

  // Reflected CRC-32 update over one nibble, LSB first
  function automatic logic [31:0] crc_nib(input logic [31:0] c_in, input logic [3:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 4; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h00000000);
    end
    return c;
  endfunction
`endif

  assign ready   = ready_r;
  assign addr    = addr_r;
  assign TX_EN   = tx_en_r;
  assign TX_DATA = tx_data_r;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bcnt_r    <= {ADDR_W{1'b0}};
      nbytes_r  <= {ADDR_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      half_r    <= 1'b0;
      hold_r    <= 4'h0;
      tx_en_r   <= 1'b0;
      tx_data_r <= 4'h0;
      ready_r   <= 1'b1;
`ifdef ETH_TX_FCS_EN
      crc_r     <= 32'hFFFFFFFF;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bcnt_r    <= bcnt_s;
      nbytes_r  <= nbytes_s;
      addr_r    <= addr_s;
      half_r    <= half_s;
      hold_r    <= hold_s;
      tx_en_r   <= tx_en_s;
      tx_data_r <= tx_data_s;
      ready_r   <= ready_s;
`ifdef ETH_TX_FCS_EN
      crc_r     <= crc_s;
`endif
    end
  end

  // Next-state and next-output decode; outputs describe the nibble shown in the next cycle
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bcnt_s    = bcnt_r;
    nbytes_s  = nbytes_r;
    addr_s    = addr_r;
    half_s    = half_r;
    hold_s    = hold_r;
    tx_en_s   = tx_en_r;
    tx_data_s = tx_data_r;
    ready_s   = ready_r;
`ifdef ETH_TX_FCS_EN
    crc_s     = crc_r;
`endif
    case (state_r)
      IDLE: begin
        addr_s = {ADDR_W{1'b0}};
        if (send && (nbytes != {ADDR_W{1'b0}})) begin
          state_s   = PRE;
          nbytes_s  = nbytes;
          cnt_s     = {CNT_W{1'b0}};
          tx_en_s   = 1'b1;
          tx_data_s = 4'h5;
          ready_s   = 1'b0;
`ifdef ETH_TX_FCS_EN
          crc_s     = 32'hFFFFFFFF;
`endif
        end else begin
          tx_en_s   = 1'b0;
          tx_data_s = 4'h0;
          ready_s   = 1'b1;
        end
      end
      PRE: begin
        if (cnt_r == CNT_W'(15)) begin
          // byte 0 was prefetched at addr 0; request byte 1 now so it lands in two cycles
          state_s   = DATA;
          bcnt_s    = {ADDR_W{1'b0}};
          half_s    = 1'b0;
          tx_data_s = data[3:0];
          hold_s    = data[7:4];
`ifdef ETH_TX_FCS_EN
          crc_s     = crc_nib(crc_r, data[3:0]);
`endif
          if (addr_r != nbytes_r - ADDR_W'(1)) begin
            addr_s = addr_r + ADDR_W'(1);
          end else begin
            addr_s = addr_r;
          end
        end else begin
          cnt_s     = cnt_r + CNT_W'(1);
          tx_data_s = (cnt_r == CNT_W'(14)) ? 4'hD : 4'h5;
        end
      end
      DATA: begin
        if (!half_r) begin
          half_s    = 1'b1;
          tx_data_s = hold_r;
`ifdef ETH_TX_FCS_EN
          crc_s     = crc_nib(crc_r, hold_r);
`endif
        end else if (bcnt_r == nbytes_r - ADDR_W'(1)) begin
          cnt_s = {CNT_W{1'b0}};
`ifdef ETH_TX_FCS_EN
          state_s   = FCS;
          tx_data_s = ~crc_r[3:0];
          crc_s     = {4'hF, crc_r[31:4]};
`else
          state_s   = IFG;
          tx_en_s   = 1'b0;
          tx_data_s = 4'h0;
`endif
        end else begin
          bcnt_s    = bcnt_r + ADDR_W'(1);
          half_s    = 1'b0;
          tx_data_s = data[3:0];
          hold_s    = data[7:4];
`ifdef ETH_TX_FCS_EN
          crc_s     = crc_nib(crc_r, data[3:0]);
`endif
          if (addr_r != nbytes_r - ADDR_W'(1)) begin
            addr_s = addr_r + ADDR_W'(1);
          end else begin
            addr_s = addr_r;
          end
        end
      end
`ifdef ETH_TX_FCS_EN
      FCS: begin
        if (cnt_r == CNT_W'(7)) begin
          state_s   = IFG;
          cnt_s     = {CNT_W{1'b0}};
          tx_en_s   = 1'b0;
          tx_data_s = 4'h0;
        end else begin
          cnt_s     = cnt_r + CNT_W'(1);
          tx_data_s = ~crc_r[3:0];
          crc_s     = {4'hF, crc_r[31:4]};
        end
      end
`endif
      IFG: begin
        if (cnt_r == CNT_W'(IFG_NIBBLES - 1)) begin
          state_s = IDLE;
          ready_s = 1'b1;
          addr_s  = {ADDR_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s   = IDLE;
        tx_en_s   = 1'b0;
        tx_data_s = 4'h0;
        ready_s   = 1'b1;
        addr_s    = {ADDR_W{1'b0}};
      end
    endcase
  end

endmodule
